// File: rtl/elevator_pkg.sv
// Shared elevator-controller definitions: display code layout, direction
// decoding and the floor-index width helper.
package elevator_pkg;

    // Per-floor display code for the scan display
    localparam int              DISP_W          = 5;
    localparam logic [4:0]      DISP_BLANK      = 5'b00000;
    localparam int              DISP_UP_BIT     = 0;
    localparam int              DISP_DN_BIT     = 1;
    localparam logic [4:0]      DISP_FLOOR_BASE = 5'b10000;

    // Car travel commitment as seen by the call register
    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10
    } dir_e;

    // Width of a floor index; never narrower than one bit
    function automatic int floor_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Both direction lines equal (both low or both high) means idle
    function automatic dir_e decode_dir(input logic up, input logic dn);
        if (up && !dn) begin
            return DIR_UP;
        end
        if (dn && !up) begin
            return DIR_DN;
        end
        return DIR_IDLE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One hall button: 2-flop synchroniser, stability counter, accepted level
// and a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DEBOUNCE = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);

    localparam int            CW       = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;

    // Bring the raw button into the clock domain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the stable one for DEBOUNCE edges
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Delayed copy of the stable level for rise detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign o_rise = r_stable & ~r_stable_d;

endmodule

// File: rtl/hall_call_reg.sv
// Hall-call register: debounces up/down hall buttons for every floor,
// latches presses as pending calls, clears them when the car serves the
// floor, and exports dispatcher summaries and display codes.
module hall_call_reg
    import elevator_pkg::*;
#(
    parameter int FLOORS   = 4,
    parameter int DEBOUNCE = 20,
    parameter int FLW      = floor_w(FLOORS)
) (
    input  logic                clk_1khz,
    input  logic                rst,
    input  logic [FLOORS-1:0]   btn_up,
    input  logic [FLOORS-1:0]   btn_dn,
    input  logic [FLW-1:0]      cur_floor,
    input  logic                door_open,
    input  logic                dir_up,
    input  logic                dir_dn,
    output logic [FLOORS-1:0]   call_up,
    output logic [FLOORS-1:0]   call_dn,
    output logic                any_above,
    output logic                any_below,
    output logic [5*FLOORS-1:0] disp
);

    logic [FLOORS-1:0] w_rise_up;
    logic [FLOORS-1:0] w_rise_dn;
    logic [FLOORS-1:0] w_here;
    logic [FLOORS-1:0] w_clr_up;
    logic [FLOORS-1:0] w_clr_dn;
    logic [FLOORS-1:0] r_call_up;
    logic [FLOORS-1:0] r_call_dn;
    logic [31:0]       w_cur_ext;
    logic              w_floor_ok;
    dir_e              w_dir;
    logic [DISP_W-1:0] w_code [FLOORS];
    logic              w_unused;

    // Top floor has no up button and ground has no down button
    assign w_unused = btn_up[FLOORS-1] ^ btn_dn[0];

    for (genvar g = 0; g < FLOORS; g++) begin : g_floor
        if (g < FLOORS - 1) begin : g_up
            btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
                .i_clk  (clk_1khz),
                .i_rst  (rst),
                .i_btn  (btn_up[g]),
                .o_rise (w_rise_up[g])
            );
        end else begin : g_up_none
            assign w_rise_up[g] = 1'b0;
        end

        if (g > 0) begin : g_dn
            btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
                .i_clk  (clk_1khz),
                .i_rst  (rst),
                .i_btn  (btn_dn[g]),
                .o_rise (w_rise_dn[g])
            );
        end else begin : g_dn_none
            assign w_rise_dn[g] = 1'b0;
        end

        assign disp[g*DISP_W +: DISP_W] = w_code[g];
    end

    assign w_cur_ext  = 32'(cur_floor);
    assign w_floor_ok = (w_cur_ext < 32'(FLOORS));
    assign w_dir      = decode_dir(dir_up, dir_dn);

    // Service clear: door open at a floor clears the call(s) matching the travel direction
    always_comb begin
        w_here   = '0;
        w_clr_up = '0;
        w_clr_dn = '0;
        for (int f = 0; f < FLOORS; f++) begin
            w_here[f]   = door_open && w_floor_ok && (w_cur_ext == 32'(f));
            w_clr_up[f] = w_here[f] && (w_dir != DIR_DN);
            w_clr_dn[f] = w_here[f] && (w_dir != DIR_UP);
        end
    end

    // Latch presses; a clear on the same edge drops the press since it is already being served
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            r_call_up <= '0;
            r_call_dn <= '0;
        end else begin
            for (int f = 0; f < FLOORS; f++) begin
                if (w_clr_up[f]) begin
                    r_call_up[f] <= 1'b0;
                end else if (w_rise_up[f]) begin
                    r_call_up[f] <= 1'b1;
                end
                if (w_clr_dn[f]) begin
                    r_call_dn[f] <= 1'b0;
                end else if (w_rise_dn[f]) begin
                    r_call_dn[f] <= 1'b1;
                end
            end
            r_call_up[FLOORS-1] <= 1'b0;
            r_call_dn[0]        <= 1'b0;
        end
    end

    assign call_up = r_call_up;
    assign call_dn = r_call_dn;

    // Dispatcher summaries; calls at the car's own floor count toward neither side
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        if (w_floor_ok) begin
            for (int f = 0; f < FLOORS; f++) begin
                if (r_call_up[f] || r_call_dn[f]) begin
                    if (32'(f) > w_cur_ext) begin
                        any_above = 1'b1;
                    end
                    if (32'(f) < w_cur_ext) begin
                        any_below = 1'b1;
                    end
                end
            end
        end
    end

    // Per-floor display code built from the latched calls
    always_comb begin
        for (int f = 0; f < FLOORS; f++) begin
            w_code[f]              = DISP_BLANK;
            w_code[f][DISP_UP_BIT] = r_call_up[f];
            w_code[f][DISP_DN_BIT] = r_call_dn[f];
        end
    end

endmodule

// File: tb/tb_hall_call_reg.sv
// Directed bench for hall_call_reg (4 floors, 20-cycle debounce).
module tb_hall_call_reg;

    logic        clk_1khz;
    logic        rst;
    logic [3:0]  btn_up;
    logic [3:0]  btn_dn;
    logic [1:0]  cur_floor;
    logic        door_open;
    logic        dir_up;
    logic        dir_dn;
    logic [3:0]  call_up;
    logic [3:0]  call_dn;
    logic        any_above;
    logic        any_below;
    logic [19:0] disp;

    int n_tests = 0;
    int n_fail  = 0;

    hall_call_reg #(.FLOORS(4), .DEBOUNCE(20)) dut (
        .clk_1khz  (clk_1khz),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .cur_floor (cur_floor),
        .door_open (door_open),
        .dir_up    (dir_up),
        .dir_dn    (dir_dn),
        .call_up   (call_up),
        .call_dn   (call_dn),
        .any_above (any_above),
        .any_below (any_below),
        .disp      (disp)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    typedef struct {
        logic [3:0] bu;
        logic [3:0] bd;
        logic [1:0] cf;
        logic       door;
        logic       du;
        logic       dd;
        int         cyc;
        logic [3:0] eu;
        logic [3:0] ed;
        logic       ea;
        logic       eb;
    } vec_t;

    vec_t tv [15];

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_1khz);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] disp_of(input logic [3:0] u, input logic [3:0] d);
        logic [19:0] r;
        r = '0;
        for (int f = 0; f < 4; f++) begin
            r[f*5 +: 5] = {3'b000, d[f], u[f]};
        end
        return r;
    endfunction

    initial begin
        //                 bu       bd       cf     dr  du  dd  cyc  eu       ed       ea  eb
        tv[0]  = '{4'b0000, 4'b0000, 2'd0, 0, 0, 0, 2,  4'b0000, 4'b0000, 0, 0};
        tv[1]  = '{4'b0000, 4'b0100, 2'd0, 0, 0, 0, 10, 4'b0000, 4'b0000, 0, 0};
        tv[2]  = '{4'b0000, 4'b0000, 2'd0, 0, 0, 0, 30, 4'b0000, 4'b0000, 0, 0};
        tv[3]  = '{4'b0010, 4'b0000, 2'd0, 0, 0, 0, 25, 4'b0010, 4'b0000, 1, 0};
        tv[4]  = '{4'b0000, 4'b0000, 2'd1, 1, 0, 1, 3,  4'b0010, 4'b0000, 0, 0};
        tv[5]  = '{4'b0000, 4'b0000, 2'd1, 1, 1, 0, 1,  4'b0000, 4'b0000, 0, 0};
        tv[6]  = '{4'b1000, 4'b0001, 2'd0, 0, 0, 0, 50, 4'b0000, 4'b0000, 0, 0};
        tv[7]  = '{4'b0100, 4'b0100, 2'd2, 1, 0, 0, 30, 4'b0000, 4'b0000, 0, 0};
        tv[8]  = '{4'b0000, 4'b0000, 2'd2, 0, 0, 0, 25, 4'b0000, 4'b0000, 0, 0};
        tv[9]  = '{4'b0100, 4'b0100, 2'd0, 0, 0, 0, 25, 4'b0100, 4'b0100, 1, 0};
        tv[10] = '{4'b0000, 4'b0000, 2'd3, 0, 0, 0, 25, 4'b0100, 4'b0100, 0, 1};
        tv[11] = '{4'b0000, 4'b0000, 2'd2, 0, 0, 0, 1,  4'b0100, 4'b0100, 0, 0};
        tv[12] = '{4'b0000, 4'b0000, 2'd2, 1, 0, 1, 1,  4'b0100, 4'b0000, 0, 0};
        tv[13] = '{4'b0001, 4'b0000, 2'd2, 1, 0, 1, 25, 4'b0101, 4'b0000, 0, 1};
        tv[14] = '{4'b0000, 4'b0000, 2'd2, 1, 1, 1, 1,  4'b0001, 4'b0000, 0, 1};

        rst       = 1'b1;
        btn_up    = '0;
        btn_dn    = '0;
        cur_floor = '0;
        door_open = 1'b0;
        dir_up    = 1'b0;
        dir_dn    = 1'b0;
        step(3);

        chk("reset call_up",   32'(call_up),   32'h0);
        chk("reset call_dn",   32'(call_dn),   32'h0);
        chk("reset any_above", 32'(any_above), 32'h0);
        chk("reset any_below", 32'(any_below), 32'h0);
        chk("reset disp",      32'(disp),      32'h0);

        // Reset asserted mid-debounce throws away the partial count
        rst    = 1'b0;
        btn_up = 4'b0010;
        step(10);
        #2 rst = 1'b1;
        #1;
        chk("middeb rst call_up", 32'(call_up), 32'h0);
        step(3);
        rst = 1'b0;
        step(22);
        chk("latency edge21 call_up", 32'(call_up), 32'h0);
        step(1);
        chk("latency edge22 call_up", 32'(call_up), 32'b0010);
        chk("latency any_above",      32'(any_above), 32'h1);

        // Asynchronous reset clears a latched call without waiting for a clock edge
        #2 rst = 1'b1;
        #1;
        chk("async rst call_up",   32'(call_up),   32'h0);
        chk("async rst disp",      32'(disp),      32'h0);
        chk("async rst any_above", 32'(any_above), 32'h0);
        btn_up = '0;
        step(3);
        rst = 1'b0;
        step(2);

        for (int i = 0; i < 15; i++) begin
            btn_up    = tv[i].bu;
            btn_dn    = tv[i].bd;
            cur_floor = tv[i].cf;
            door_open = tv[i].door;
            dir_up    = tv[i].du;
            dir_dn    = tv[i].dd;
            step(tv[i].cyc);
            chk($sformatf("v%0d call_up", i),   32'(call_up),   32'(tv[i].eu));
            chk($sformatf("v%0d call_dn", i),   32'(call_dn),   32'(tv[i].ed));
            chk($sformatf("v%0d any_above", i), 32'(any_above), 32'(tv[i].ea));
            chk($sformatf("v%0d any_below", i), 32'(any_below), 32'(tv[i].eb));
            chk($sformatf("v%0d disp", i),      32'(disp),      32'(disp_of(tv[i].eu, tv[i].ed)));
            if (i == 3) begin
                chk("v3 disp floor1", 32'(disp[9:5]), 32'b00001);
            end
            if (i == 9) begin
                chk("v9 disp floor2", 32'(disp[14:10]), 32'b00011);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
